rvvi_order_merger: RTL and testbench

- Merges retired-instruction records from NUM_SRC independent trace sources (per-hart or per-file readers) into one stream for the RVVI coverage sampler.
- Records are emitted in ascending ORDER value, with valid/ready backpressure on every side.
- Sits between the trace readers and the rvviTrace drive logic, and sequences when the sampler sees each record.

---
 rtl/rvvi_order_merger.sv | 205 ++++++++++++++++++++
 tb/tb_rvvi_order_merger.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_order_merger.sv
// Merges per-source RVVI retire records into one stream ordered by ascending ORDER.
// Optional gap checker on emitted ORDER values is enabled by RVVI_MERGE_GAP_CHECK_EN.
module rvvi_order_merger #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ORDER_W = 64,
    localparam int unsigned SRC_W  = $clog2(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic [NUM_SRC-1:0]         src_done,
    input  logic [NUM_SRC*ORDER_W-1:0] src_order,
    input  logic [NUM_SRC*32-1:0]      src_insn,
    input  logic [NUM_SRC*XLEN-1:0]    src_pc,
    input  logic [NUM_SRC-1:0]         src_trap,
    input  logic [NUM_SRC*2-1:0]       src_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ORDER_W-1:0]         out_order,
    output logic [31:0]                out_insn,
    output logic [XLEN-1:0]            out_pc,
    output logic                       out_trap,
    output logic [1:0]                 out_mode,
    output logic [SRC_W-1:0]           out_src,
    output logic                       busy,
    output logic                       all_done,
    output logic                       dup_err
`ifdef RVVI_MERGE_GAP_CHECK_EN
    ,
    output logic                       gap_err,
    output logic [15:0]                gap_count
`endif
);

    typedef enum logic [1:0] {StIdle, StMerge, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [NUM_SRC-1:0] done_q;
    logic [NUM_SRC-1:0] head_vld_q;
    logic [ORDER_W-1:0] head_order_q [NUM_SRC];
    logic [31:0]        head_insn_q  [NUM_SRC];
    logic [XLEN-1:0]    head_pc_q    [NUM_SRC];
    logic [NUM_SRC-1:0] head_trap_q;
    logic [1:0]         head_mode_q  [NUM_SRC];

    logic               out_vld_q;
    logic [ORDER_W-1:0] out_order_q;
    logic [31:0]        out_insn_q;
    logic [XLEN-1:0]    out_pc_q;
    logic               out_trap_q;
    logic [1:0]         out_mode_q;
    logic [SRC_W-1:0]   out_src_q;
    logic               dup_err_q;

    logic               active;
    logic               sel_found;
    logic [SRC_W-1:0]   sel_idx;
    logic [ORDER_W-1:0] sel_order;
    logic               tie;
    logic               fire;
    logic [NUM_SRC-1:0] xfer;

    assign active = (state_q == StMerge) || (state_q == StDrain);

    // Lowest index wins ties because only a strictly smaller order replaces the pick.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_order = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (head_vld_q[i] && (!sel_found || head_order_q[i] < sel_order)) begin
                sel_found = 1'b1;
                sel_idx   = SRC_W'(i);
                sel_order = head_order_q[i];
            end
        end
        tie = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (head_vld_q[i] && head_order_q[i] == sel_order && SRC_W'(i) != sel_idx) begin
                tie = 1'b1;
            end
        end
    end

    // Every source must have a head or be finished, otherwise a smaller order may still arrive.
    assign fire = active && (!out_vld_q || out_ready) && (&(head_vld_q | done_q)) && sel_found;

    always_comb begin
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            src_ready[i] = active && !done_q[i] &&
                           (!head_vld_q[i] || (fire && sel_idx == SRC_W'(i)));
        end
    end

    assign xfer = src_valid & src_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StMerge;
            StMerge: if (&done_q) state_d = StDrain;
            StDrain: if (!(|head_vld_q) && (!out_vld_q || out_ready)) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            done_q     <= '0;
            head_vld_q <= '0;
            head_trap_q <= '0;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                head_order_q[i] <= '0;
                head_insn_q[i]  <= '0;
                head_pc_q[i]    <= '0;
                head_mode_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q != StIdle) done_q <= done_q | src_done;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (xfer[i]) begin
                    head_vld_q[i]   <= 1'b1;
                    head_order_q[i] <= src_order[i*ORDER_W +: ORDER_W];
                    head_insn_q[i]  <= src_insn[i*32 +: 32];
                    head_pc_q[i]    <= src_pc[i*XLEN +: XLEN];
                    head_trap_q[i]  <= src_trap[i];
                    head_mode_q[i]  <= src_mode[i*2 +: 2];
                end else if (fire && sel_idx == SRC_W'(i)) begin
                    head_vld_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld_q   <= 1'b0;
            out_order_q <= '0;
            out_insn_q  <= '0;
            out_pc_q    <= '0;
            out_trap_q  <= 1'b0;
            out_mode_q  <= '0;
            out_src_q   <= '0;
            dup_err_q   <= 1'b0;
        end else begin
            if (fire) begin
                out_vld_q   <= 1'b1;
                out_order_q <= sel_order;
                out_insn_q  <= head_insn_q[sel_idx];
                out_pc_q    <= head_pc_q[sel_idx];
                out_trap_q  <= head_trap_q[sel_idx];
                out_mode_q  <= head_mode_q[sel_idx];
                out_src_q   <= sel_idx;
                if (tie) dup_err_q <= 1'b1;
            end else if (out_ready) begin
                out_vld_q <= 1'b0;
            end
        end
    end

`ifdef RVVI_MERGE_GAP_CHECK_EN
    logic               gap_seen_q;
    logic [ORDER_W-1:0] gap_exp_q;
    logic               gap_err_q;
    logic [15:0]        gap_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_seen_q <= 1'b0;
            gap_exp_q  <= '0;
            gap_err_q  <= 1'b0;
            gap_cnt_q  <= '0;
        end else if (fire) begin
            gap_seen_q <= 1'b1;
            gap_exp_q  <= sel_order + ORDER_W'(1);
            if (gap_seen_q && sel_order != gap_exp_q) begin
                gap_err_q <= 1'b1;
                if (gap_cnt_q != 16'hffff) gap_cnt_q <= gap_cnt_q + 16'd1;
            end
        end
    end

    assign gap_err   = gap_err_q;
    assign gap_count = gap_cnt_q;
`endif

    assign out_valid = out_vld_q;
    assign out_order = out_order_q;
    assign out_insn  = out_insn_q;
    assign out_pc    = out_pc_q;
    assign out_trap  = out_trap_q;
    assign out_mode  = out_mode_q;
    assign out_src   = out_src_q;
    assign busy      = active;
    assign all_done  = (state_q == StDone);
    assign dup_err   = dup_err_q;

endmodule

// File: tb/tb_rvvi_order_merger.sv
// Directed bench for rvvi_order_merger with two sources; per-source record queues feed the DUT
// and accepted outputs are collected for comparison against hand-written sequences.
module tb_rvvi_order_merger;

    localparam int unsigned NS = 2;

    logic           clk;
    logic           reset_n;
    logic           start;
    logic [NS-1:0]  src_valid;
    logic [NS-1:0]  src_ready;
    logic [NS-1:0]  src_done;
    logic [NS*64-1:0] src_order;
    logic [NS*32-1:0] src_insn;
    logic [NS*64-1:0] src_pc;
    logic [NS-1:0]  src_trap;
    logic [NS*2-1:0] src_mode;
    logic           out_valid;
    logic           out_ready;
    logic [63:0]    out_order;
    logic [31:0]    out_insn;
    logic [63:0]    out_pc;
    logic           out_trap;
    logic [1:0]     out_mode;
    logic [0:0]     out_src;
    logic           busy;
    logic           all_done;
    logic           dup_err;
`ifdef RVVI_MERGE_GAP_CHECK_EN
    logic           gap_err;
    logic [15:0]    gap_count;
`endif

    rvvi_order_merger #(.NUM_SRC(NS), .XLEN(64), .ORDER_W(64)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src_valid(src_valid), .src_ready(src_ready), .src_done(src_done),
        .src_order(src_order), .src_insn(src_insn), .src_pc(src_pc),
        .src_trap(src_trap), .src_mode(src_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
        .out_insn(out_insn), .out_pc(out_pc), .out_trap(out_trap), .out_mode(out_mode),
        .out_src(out_src), .busy(busy), .all_done(all_done), .dup_err(dup_err)
`ifdef RVVI_MERGE_GAP_CHECK_EN
        , .gap_err(gap_err), .gap_count(gap_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] got_order[$];
    logic [63:0] got_src[$];
    logic [63:0] got_pc[$];
    logic [NS-1:0] auto_done;
    logic [NS-1:0] early_done;
    logic dup_first;
    logic saw_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input int idx, input logic [63:0] ord, input logic [63:0] src);
        logic [63:0] o, s;
        o = (idx < got_order.size()) ? got_order[idx] : 64'hdead_dead_dead_dead;
        s = (idx < got_src.size()) ? got_src[idx] : 64'hdead_dead_dead_dead;
        chk($sformatf("rec%0d_order", idx), o, ord);
        chk($sformatf("rec%0d_src", idx), s, src);
    endtask

    task automatic drive_src();
        logic [63:0] o0, o1;
        o0 = 64'd0;
        o1 = 64'd0;
        if (q0.size() != 0) o0 = q0[0];
        if (q1.size() != 0) o1 = q1[0];
        src_valid[0] = (q0.size() != 0);
        src_valid[1] = (q1.size() != 0);
        src_done[0]  = auto_done[0] && (q0.size() <= (early_done[0] ? 1 : 0));
        src_done[1]  = auto_done[1] && (q1.size() <= (early_done[1] ? 1 : 0));
        src_order    = {o1, o0};
        src_insn     = {o1[31:0] + 32'h13, o0[31:0] + 32'h13};
        src_pc       = {64'h8000_0000 + (o1 << 2), 64'h8000_0000 + (o0 << 2)};
        src_trap     = '0;
        src_mode     = {2'b11, 2'b11};
    endtask

    // Inputs change 1 time unit after the rising edge; handshakes are sampled on the falling edge.
    task automatic cycle();
        logic [NS-1:0] xfer;
        @(negedge clk);
        xfer = src_valid & src_ready;
        if (out_valid && out_ready) begin
            if (got_order.size() == 0) dup_first = dup_err;
            got_order.push_back(out_order);
            got_src.push_back(64'(out_src));
            got_pc.push_back(out_pc);
        end
        @(posedge clk);
        #1;
        if (xfer[0]) void'(q0.pop_front());
        if (xfer[1]) void'(q1.pop_front());
        drive_src();
    endtask

    task automatic run_until_done(input string tag, input int max_cyc);
        saw_busy = 1'b0;
        for (int k = 0; k < max_cyc && !all_done; k++) begin
            saw_busy = busy;
            cycle();
        end
        chk({tag, "_done"}, 64'(all_done), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        auto_done = '0;
        early_done = '0;
        dup_first = 1'b0;
        q0.delete();
        q1.delete();
        got_order.delete();
        got_src.delete();
        got_pc.delete();
        drive_src();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        do_reset();

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_order", out_order, 64'd0);
        chk("rst_src_ready", 64'(src_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_all_done", 64'(all_done), 64'd0);
        chk("rst_dup_err", 64'(dup_err), 64'd0);

        // Interleaved sources
        q0 = '{64'd0, 64'd2, 64'd4};
        q1 = '{64'd1, 64'd3, 64'd5};
        auto_done = 2'b11;
        drive_src();
        pulse_start();
        chk("t1_busy", 64'(busy), 64'd1);
        run_until_done("t1", 60);
        chk("t1_count", 64'(got_order.size()), 64'd6);
        for (int i = 0; i < 6; i++) chk_rec(i, 64'(i), 64'(i % 2));
        chk("t1_pc3", (got_pc.size() > 3) ? got_pc[3] : 64'd0, 64'h8000_000c);
        chk("t1_dup", 64'(dup_err), 64'd0);
        chk("t1_start_ignored_busy", 64'(busy), 64'd0);
        pulse_start();
        chk("t1_start_ignored", 64'(all_done), 64'd1);

        // Source 1 done without records; source 0 asserts done alongside its last record
        do_reset();
        q0 = '{64'd7, 64'd8};
        auto_done = 2'b11;
        early_done = 2'b01;
        drive_src();
        pulse_start();
        run_until_done("t2", 40);
        chk("t2_count", 64'(got_order.size()), 64'd2);
        chk_rec(0, 64'd7, 64'd0);
        chk_rec(1, 64'd8, 64'd0);
        chk("t2_busy_before_done", 64'(saw_busy), 64'd1);

        // No records at all: DONE two edges after done_q is captured
        do_reset();
        auto_done = 2'b11;
        drive_src();
        pulse_start();
        chk("t3_e0_busy", 64'(busy), 64'd1);
        cycle();
        chk("t3_e1_done", 64'(all_done), 64'd0);
        cycle();
        chk("t3_e2_busy", 64'(busy), 64'd1);
        chk("t3_e2_done", 64'(all_done), 64'd0);
        cycle();
        chk("t3_e3_done", 64'(all_done), 64'd1);
        chk("t3_e3_busy", 64'(busy), 64'd0);
        chk("t3_out_valid", 64'(out_valid), 64'd0);

        // Equal orders
        do_reset();
        q0 = '{64'd5};
        q1 = '{64'd5};
        auto_done = 2'b11;
        drive_src();
        pulse_start();
        run_until_done("t4", 40);
        chk("t4_count", 64'(got_order.size()), 64'd2);
        chk_rec(0, 64'd5, 64'd0);
        chk_rec(1, 64'd5, 64'd1);
        chk("t4_dup_first", 64'(dup_first), 64'd1);
        chk("t4_dup_sticky", 64'(dup_err), 64'd1);

        // Output stall with three records queued
        do_reset();
        q0 = '{64'd1, 64'd3};
        q1 = '{64'd2};
        auto_done = 2'b11;
        out_ready = 1'b0;
        drive_src();
        pulse_start();
        cycle();
        cycle();
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("t5_hold_valid", 64'(out_valid), 64'd1);
            chk("t5_hold_order", out_order, 64'd1);
            chk("t5_hold_ready", 64'(src_ready), 64'd0);
        end
        chk("t5_insn", 64'(out_insn), 64'h14);
        chk("t5_mode", 64'(out_mode), 64'd3);
        out_ready = 1'b1;
        run_until_done("t5", 40);
        chk("t5_count", 64'(got_order.size()), 64'd3);
        chk_rec(0, 64'd1, 64'd0);
        chk_rec(1, 64'd2, 64'd1);
        chk_rec(2, 64'd3, 64'd0);

        // Asynchronous reset mid-stream, then a fresh run
        do_reset();
        q0 = '{64'd20};
        q1 = '{64'd21};
        auto_done = 2'b11;
        out_ready = 1'b0;
        drive_src();
        pulse_start();
        cycle();
        cycle();
        chk("t6_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        chk("t6_async_order", out_order, 64'd0);
        chk("t6_async_busy", 64'(busy), 64'd0);
        chk("t6_async_ready", 64'(src_ready), 64'd0);
        do_reset();
        q0 = '{64'd30};
        q1 = '{64'd31};
        auto_done = 2'b11;
        drive_src();
        pulse_start();
        run_until_done("t6", 40);
        chk("t6_count", 64'(got_order.size()), 64'd2);
        chk_rec(0, 64'd30, 64'd0);
        chk_rec(1, 64'd31, 64'd1);

`ifdef RVVI_MERGE_GAP_CHECK_EN
        do_reset();
        chk("t7_gap_rst", 64'(gap_err), 64'd0);
        q0 = '{64'd10, 64'd13};
        q1 = '{64'd11};
        auto_done = 2'b11;
        drive_src();
        pulse_start();
        run_until_done("t7", 40);
        chk("t7_count", 64'(got_order.size()), 64'd3);
        chk("t7_gap_err", 64'(gap_err), 64'd1);
        chk("t7_gap_count", 64'(gap_count), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
